// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- byte-wide UART transmitter, 8N1 framing, LSB first.
//
// A parallel producer raises `en` with a byte on `data`. When the transmitter
// is idle, the byte is latched and shifted out on `txd` as one start bit
// (low), eight data bits (LSB first) and one stop bit (high). Each bit is held
// for CLKS_PER_BIT clock cycles. `done` pulses for one cycle when the frame
// completes.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   When defined, an even-parity bit (XOR of the eight data bits) is sent
//   between the last data bit and the stop bit. The frame is then
//   11*CLKS_PER_BIT cycles long. When undefined, no parity logic exists.
//
// Parameters:
//   CLK_FREQ      system clock frequency in Hz
//   BAUD          line rate in bits/s
//   CLKS_PER_BIT  clock cycles per serial bit (CLK_FREQ/BAUD, truncated)
//
// Ports:
//   clk   in   1  system clock, rising edge
//   rstn  in   1  synchronous reset, active high (1 = reset)
//   en    in   1  transmit request, sampled only while idle
//   data  in   8  byte to send, latched when the frame starts
//   done  out  1  one-cycle pulse marking the end of the stop bit
//   txd   out  1  serial line, idle high, driven straight from a flop
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [7:0] data,
    output logic       done,
    output logic       txd
);

    // A divider of 1 still needs a one-bit counter to keep the widths legal.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
    logic             done_q, done_d;
    logic             lastTick;
`ifdef UART_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // The current bit period ends on the cycle the baud counter hits its top.
    assign lastTick = (cnt_q == CNT_MAX);

    // State register. Reset wins over everything, including a frame in flight,
    // so an abort drives the line high on the very next cycle.
    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bitIdx_q <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic. The byte is captured only on the IDLE->START edge, so
    // later changes on `data` cannot disturb the frame. The shift register
    // moves one place right at each data-bit boundary, keeping the bit on the
    // line at shift_q[0].
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d  = START;
                    bitIdx_d = '0;
                    shift_d  = data;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^data;
`endif
                end
            end
            START: begin
                if (lastTick) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DATA: begin
                if (lastTick) begin
                    cnt_d = '0;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                        shift_d  = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (lastTick) begin
                    cnt_d   = '0;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
`endif
            STOP: begin
                if (lastTick) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic. The line level is computed from the state being entered
    // and then registered, so txd changes exactly on the edge that starts a
    // bit and can never glitch. done is registered on the edge that ends the
    // stop bit, so it is high during the single idle cycle that separates
    // frames.
    always_comb begin
        txd_d  = 1'b1;
        done_d = (state_q == STOP) && lastTick;
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_d = parity_d;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    assign txd  = txd_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed self-checking bench for uart_tx at default baud.
// Every scenario task drives its own stimulus and compares txd/done each
// cycle against hand-derived frame contents. Inputs are driven and outputs
// sampled on the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int CPB = 50_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [7:0] data;
    logic       done;
    logic       txd;

    int checks   = 0;
    int failures = 0;

    uart_tx dut (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .data (data),
        .done (done),
        .txd  (txd)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    // Expected line level c cycles after the edge that sampled en.
    function automatic logic expTxd(input logic [7:0] b, input int c);
        int k;
        k = c / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Reset held 10 cycles with en low, then released with the line quiet.
    task automatic test_reset();
        rstn = 1'b1;
        en   = 1'b0;
        data = 8'h00;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1) begin
                failures++;
                $display("[TB] FAIL reset_txd got=%b exp=1", txd);
            end
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_done got=%b exp=0", done);
            end
        end
        rstn = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_idle txd=%b done=%b exp txd=1 done=0", txd, done);
            end
        end
    endtask

    // Alternating byte: every bit boundary toggles the line.
    task automatic test_frame55();
        logic expT;
        logic expD;
        @(negedge clk);
        en   = 1'b1;
        data = 8'h55;
        @(posedge clk);
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            expT = (c < FRAME) ? expTxd(8'h55, c) : 1'b1;
            expD = (c == FRAME);
            checks++;
            if (txd !== expT) begin
                failures++;
                $display("[TB] FAIL frame55_txd cycle=%0d got=%b exp=%b", c, txd, expT);
            end
            checks++;
            if (done !== expD) begin
                failures++;
                $display("[TB] FAIL frame55_done cycle=%0d got=%b exp=%b", c, done, expD);
            end
            if (c == 0) en = 1'b0;
        end
    endtask

    // 100 us of idle line with en low: nothing may happen.
    task automatic test_idle_gap();
        repeat (5000) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_gap txd=%b done=%b exp txd=1 done=0", txd, done);
            end
        end
    endtask

    // Byte 0x15 with data changed to 0xFF mid-frame; the frame must not move.
    task automatic test_data_change();
        logic expT;
        logic expD;
        @(negedge clk);
        en   = 1'b1;
        data = 8'h15;
        @(posedge clk);
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            expT = (c < FRAME) ? expTxd(8'h15, c) : 1'b1;
            expD = (c == FRAME);
            checks++;
            if (txd !== expT) begin
                failures++;
                $display("[TB] FAIL frame15_txd cycle=%0d got=%b exp=%b", c, txd, expT);
            end
            checks++;
            if (done !== expD) begin
                failures++;
                $display("[TB] FAIL frame15_done cycle=%0d got=%b exp=%b", c, done, expD);
            end
            if (c == 0) en = 1'b0;
            if (c == 2 * CPB) data = 8'hFF;
        end
    endtask

    // en held high: two frames separated by exactly one idle-high cycle. The
    // second frame must carry the byte present when it starts.
    task automatic test_back_to_back();
        logic       expT;
        logic       expD;
        logic [7:0] b;
        int         o;
        @(negedge clk);
        en   = 1'b1;
        data = 8'hA3;
        @(posedge clk);
        for (int c = 0; c <= 2 * FRAME + 1; c++) begin
            @(negedge clk);
            o    = c % (FRAME + 1);
            b    = (c <= FRAME) ? 8'hA3 : 8'h3C;
            expT = (o < FRAME) ? expTxd(b, o) : 1'b1;
            expD = (o == FRAME);
            checks++;
            if (txd !== expT) begin
                failures++;
                $display("[TB] FAIL b2b_txd cycle=%0d got=%b exp=%b", c, txd, expT);
            end
            checks++;
            if (done !== expD) begin
                failures++;
                $display("[TB] FAIL b2b_done cycle=%0d got=%b exp=%b", c, done, expD);
            end
            if (c == 10) data = 8'h3C;
            if (c == 2 * FRAME + 1) en = 1'b0;
        end
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL b2b_after txd=%b done=%b exp txd=1 done=0", txd, done);
            end
        end
    endtask

    // Reset during data bit 3 aborts the frame; a fresh request then works.
    task automatic test_abort();
        logic expT;
        logic expD;
        int   abortAt;
        abortAt = 4 * CPB + 100;
        @(negedge clk);
        en   = 1'b1;
        data = 8'h55;
        @(posedge clk);
        for (int c = 0; c <= abortAt; c++) begin
            @(negedge clk);
            expT = expTxd(8'h55, c);
            checks++;
            if (txd !== expT || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_pre cycle=%0d txd=%b done=%b exp txd=%b done=0", c, txd, done, expT);
            end
            if (c == 0) en = 1'b0;
            if (c == abortAt) rstn = 1'b1;
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_reset txd=%b done=%b exp txd=1 done=0", txd, done);
            end
        end
        rstn = 1'b0;
        repeat (FRAME + 10) begin
            @(negedge clk);
            checks++;
            if (txd !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL abort_quiet txd=%b done=%b exp txd=1 done=0", txd, done);
            end
        end
        @(negedge clk);
        en   = 1'b1;
        data = 8'hC6;
        @(posedge clk);
        for (int c = 0; c <= FRAME; c++) begin
            @(negedge clk);
            expT = (c < FRAME) ? expTxd(8'hC6, c) : 1'b1;
            expD = (c == FRAME);
            checks++;
            if (txd !== expT) begin
                failures++;
                $display("[TB] FAIL abort_fresh_txd cycle=%0d got=%b exp=%b", c, txd, expT);
            end
            checks++;
            if (done !== expD) begin
                failures++;
                $display("[TB] FAIL abort_fresh_done cycle=%0d got=%b exp=%b", c, done, expD);
            end
            if (c == 0) en = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] uart_tx bench, CLKS_PER_BIT=%0d, frame=%0d cycles", CPB, FRAME);
        test_reset();
        test_frame55();
        test_idle_gap();
        test_data_change();
        test_back_to_back();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
